// File: rtl/fetch_queue.sv
// fetch_queue -- instruction prefetch buffer between instruction memory and
// the IF/ID pipeline register.
//
// Issues sequential fetch requests, tracks in-order memory responses and
// buffers up to DEPTH {pc, instr} pairs. The head entry is presented to decode
// one per cycle. A redirect flushes queued entries, marks every in-flight
// response for discard and restarts fetching at the redirect PC.
//
// Optional feature macro: FETCHQ_BYPASS_EN
//   When defined, a response arriving while the queue is empty, nothing is
//   being dropped and no redirect is active drives valid_o/instr_o/pc_o
//   combinationally in the same cycle. If it is consumed (stall_i=0) it is
//   never written to the queue.
//   When undefined, every response goes through the queue and the decode-side
//   outputs come straight from registers.
//
// Ports
//   clk_i          in   clock, all state updates on the rising edge
//   rst_i          in   synchronous active-high reset
//   imem_req_o     out  fetch request valid
//   imem_addr_o    out  fetch address (current fetch PC)
//   imem_gnt_i     in   request accepted this cycle (only with imem_req_o)
//   imem_rvalid_i  in   response valid, in request order
//   imem_rdata_i   in   response instruction
//   redirect_i     in   flush and restart fetch
//   redirect_pc_i  in   new fetch PC
//   stall_i        in   downstream not accepting this cycle
//   valid_o        out  instr_o/pc_o hold a real instruction
//   instr_o        out  head instruction, NOP when valid_o=0
//   pc_o           out  PC of instr_o, 0 when valid_o=0
//
// Decode handshake: an instruction is transferred in every cycle where
// valid_o=1 and stall_i=0 (and no redirect). While stall_i=1 the presented
// entry and all decode-side outputs hold steady.

module fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  input  logic              stall_i,
  output logic              valid_o,
  output logic [INST_W-1:0] instr_o,
  output logic [ADDR_W-1:0] pc_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Two extra bits so count + outstanding never wraps, even right after a
  // redirect when stale requests are still in flight.
  localparam int CNT_W = PTR_W + 2;
  localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);

  // Architectural state
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic [ADDR_W-1:0] r_q_pc    [DEPTH];
  logic [INST_W-1:0] r_q_instr [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  r_outstanding;
  logic [CNT_W-1:0]  r_drop_cnt;

  // Derived control
  logic [CNT_W-1:0] w_live;
  logic             w_req;
  logic             w_grant;
  logic             w_resp;
  logic             w_accept;
  logic             w_bypass;
  logic             w_q_valid;
  logic             w_pop;
  logic             w_push;

  // Entries on the current fetch path that are either queued or still in
  // flight. Responses that will be dropped do not occupy a slot.
  assign w_live = r_count + r_outstanding - r_drop_cnt;

  assign w_req   = !rst_i && !redirect_i && (w_live < CNT_W'(DEPTH));
  assign w_grant = w_req && imem_gnt_i;

  // A response with nothing outstanding is a leftover from before reset.
  assign w_resp   = !rst_i && imem_rvalid_i && (r_outstanding != '0);
  assign w_accept = w_resp && (r_drop_cnt == '0) && !redirect_i;

`ifdef FETCHQ_BYPASS_EN
  assign w_bypass = w_accept && (r_count == '0);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_q_valid = (r_count != '0);
  assign w_pop     = !rst_i && w_q_valid && !stall_i && !redirect_i;
  // A bypassed response that decode takes right away never enters the queue.
  assign w_push    = w_accept && !(w_bypass && !stall_i);

  assign imem_req_o  = w_req;
  assign imem_addr_o = rst_i ? RESET_PC : r_fetch_pc;

  always_comb begin
    valid_o = 1'b0;
    instr_o = NOP;
    pc_o    = '0;
    if (!rst_i) begin
      if (w_q_valid) begin
        valid_o = 1'b1;
        instr_o = r_q_instr[r_rd_ptr];
        pc_o    = r_q_pc[r_rd_ptr];
      end else if (w_bypass) begin
        valid_o = 1'b1;
        instr_o = imem_rdata_i;
        pc_o    = r_resp_pc;
      end
    end
  end

  // Control state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (redirect_i) begin
      // Everything still in flight belongs to the old path and is dropped;
      // a response arriving this very cycle is already gone.
      r_fetch_pc    <= redirect_pc_i;
      r_resp_pc     <= redirect_pc_i;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= r_outstanding - CNT_W'(w_resp);
      r_drop_cnt    <= r_outstanding - CNT_W'(w_resp);
    end else begin
      if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
      end
      if (w_accept) begin
        r_resp_pc <= r_resp_pc + ADDR_W'(4);
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_outstanding <= r_outstanding + CNT_W'(w_grant) - CNT_W'(w_resp);
      if (w_resp && (r_drop_cnt != '0)) begin
        r_drop_cnt <= r_drop_cnt - CNT_W'(1);
      end
    end
  end

  // Queue storage needs no reset: r_count gates every read.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_q_pc[r_wr_ptr]    <= r_resp_pc;
      r_q_instr[r_wr_ptr] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue. A small memory model answers granted requests after
// a programmable latency with a data word derived from the address. The
// reference model tracks, at the level of the fetch stream, which PC must be
// delivered next, which address must be requested next and how many
// current-path instructions are fetched but not yet delivered.

module tb_fetch_queue;

  localparam int          DEPTH  = 4;
  localparam int          ADDR_W = 32;
  localparam int          INST_W = 32;
  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef FETCHQ_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  // Clock / reset / DUT signals
  logic              clk           = 1'b0;
  logic              rst_i         = 1'b1;
  logic              imem_req_o;
  logic [ADDR_W-1:0] imem_addr_o;
  logic              imem_gnt_i    = 1'b0;
  logic              imem_rvalid_i = 1'b0;
  logic [INST_W-1:0] imem_rdata_i  = '0;
  logic              redirect_i    = 1'b0;
  logic [ADDR_W-1:0] redirect_pc_i = '0;
  logic              stall_i       = 1'b0;
  logic              valid_o;
  logic [INST_W-1:0] instr_o;
  logic [ADDR_W-1:0] pc_o;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .RESET_PC(RST_PC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .stall_i      (stall_i),
    .valid_o      (valid_o),
    .instr_o      (instr_o),
    .pc_o         (pc_o)
  );

  // Counters and knobs
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   lat   = 1;  // memory latency in cycles
  int   gnt_mode = 0;  // 0: always grant, 1: odd cycles, 2: never
  logic stray = 1'b0;  // force a response with nothing outstanding

  // Memory model: requests in flight, in grant order
  logic [ADDR_W-1:0] exp_q[$];
  int                due_q[$];

  // Stream-level reference model
  logic [31:0] exp_out_pc  = RST_PC;
  logic [31:0] exp_fetch   = RST_PC;
  int          live        = 0;
  int          delivered   = 0;
  int          grants      = 0;
  logic        after_redir = 1'b0;
  logic        watch       = 1'b0;
  int          watch_base  = 0;
  int          first_cyc   = -1;
  logic [31:0] first_pc    = '0;
  logic [31:0] first_instr = '0;
  int          redir_pend  = 0;
  logic        redir_rvalid = 1'b0;
  logic        redir_valid  = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Driver: one cycle of stimulus, applied 1 time unit after the rising edge.
  task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic st);
    @(posedge clk);
    #1;
    cyc++;
    rst_i         = r;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    stall_i       = st;
    imem_gnt_i    = (gnt_mode == 0) || (gnt_mode == 1 && (cyc % 2) == 1);
    if (stray) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = 32'hDEAD_BEEF;
    end else if (exp_q.size() > 0 && due_q[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(exp_q[0]);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = $urandom;
    end
  endtask

  task automatic run(input int n, input logic st);
    repeat (n) step(1'b0, 1'b0, 32'h0, st);
  endtask

  // Wait until the compare process has handled the current cycle.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Compare process: checks outputs every cycle, then advances the model.
  always @(negedge clk) begin : cmp
    logic exp_req;
    if (rst_i) begin
      chk("rst_req", imem_req_o, 1'b0);
      chk("rst_addr", imem_addr_o, RST_PC);
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_instr", instr_o, NOP);
      chk("rst_pc", pc_o, 32'h0);
      exp_out_pc  = RST_PC;
      exp_fetch   = RST_PC;
      live        = 0;
      after_redir = 1'b0;
      exp_q.delete();
      due_q.delete();
      watch      = 1'b1;
      watch_base = cyc + 1;
      first_cyc  = -1;
    end else begin
      exp_req = !redirect_i && (live < DEPTH);
      chk("req", imem_req_o, exp_req);
      if (exp_req) chk("addr", imem_addr_o, exp_fetch);
      if (after_redir) chk("valid_after_redirect", valid_o, 1'b0);
      if (valid_o === 1'b1) begin
        chk("pc", pc_o, exp_out_pc);
        chk("instr", instr_o, mem_word(exp_out_pc));
        if (watch) begin
          watch       = 1'b0;
          first_cyc   = cyc - watch_base;
          first_pc    = pc_o;
          first_instr = instr_o;
        end
      end else begin
        chk("idle_valid", valid_o, 1'b0);
        chk("idle_instr", instr_o, NOP);
        chk("idle_pc", pc_o, 32'h0);
      end
      if (redirect_i) begin
        redir_pend   = exp_q.size();
        redir_rvalid = imem_rvalid_i;
        redir_valid  = valid_o;
      end
      if (imem_rvalid_i && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      if (redirect_i) begin
        exp_out_pc  = redirect_pc_i;
        exp_fetch   = redirect_pc_i;
        live        = 0;
        after_redir = 1'b1;
        watch       = 1'b1;
        watch_base  = cyc;
        first_cyc   = -1;
      end else begin
        after_redir = 1'b0;
        if (imem_req_o && imem_gnt_i) begin
          exp_q.push_back(imem_addr_o);
          due_q.push_back(cyc + lat);
          exp_fetch = exp_fetch + 32'd4;
          live++;
          grants++;
        end
        if (valid_o && !stall_i) begin
          exp_out_pc = exp_out_pc + 32'd4;
          live--;
          delivered++;
        end
      end
    end
  end

  int          d0;
  int          g0;
  logic [15:0] stall_pat;

  initial begin
    // Reset and sequential fetch from RESET_PC, latency 1
    lat = 1;
    gnt_mode = 0;
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
    settle();
    d0 = delivered;
    run(12, 1'b0);
    settle();
    chk("reset_first_valid_cycle", first_cyc, 2 - BYP);
    chk("reset_first_pc", first_pc, 32'h0000_0100);
    chk("reset_first_instr", first_instr, 32'h0100_FEFF);
    chk("reset_stream_count", delivered - d0, 10 + BYP);

    // Stall for 10 cycles: queue fills to DEPTH, then drains in order
    g0 = grants;
    run(10, 1'b1);
    #2;
    chk("stall_req_low", imem_req_o, 1'b0);
    chk("stall_valid_high", valid_o, 1'b1);
    settle();
    chk("stall_grants", grants - g0, DEPTH - 2 + BYP);
    d0 = delivered;
    run(4, 1'b0);
    settle();
    chk("drain_count", delivered - d0, 4);

    // Redirect with several responses still outstanding, latency 3
    lat = 3;
    run(8, 1'b0);
    step(1'b0, 1'b1, 32'h0000_2000, 1'b0);
    run(10, 1'b0);
    settle();
    chk("redir_outstanding_ge2", redir_pend >= 2, 1'b1);
    chk("redir_first_latency", first_cyc, 5 - BYP);
    chk("redir_first_pc", first_pc, 32'h0000_2000);
    chk("redir_first_instr", first_instr, 32'h2000_DFFF);

    // Redirect coincident with a response and a pop, latency 2
    lat = 2;
    run(10, 1'b0);
    step(1'b0, 1'b1, 32'h0000_3000, 1'b0);
    run(8, 1'b0);
    settle();
    chk("coinc_rvalid", redir_rvalid, 1'b1);
    chk("coinc_valid", redir_valid, 1'b1);
    chk("coinc_first_latency", first_cyc, 4 - BYP);
    chk("coinc_first_pc", first_pc, 32'h0000_3000);
    chk("coinc_first_instr", first_instr, 32'h3000_CFFF);

    // Grants every other cycle, latency 3
    gnt_mode = 1;
    lat = 3;
    d0 = delivered;
    run(24, 1'b0);
    settle();
    chk("half_rate_progress", (delivered - d0) >= 8, 1'b1);

    // Back-to-back redirects
    gnt_mode = 0;
    lat = 2;
    step(1'b0, 1'b1, 32'h0000_4000, 1'b0);
    step(1'b0, 1'b1, 32'h0000_5000, 1'b0);
    run(8, 1'b0);
    settle();
    chk("b2b_first_latency", first_cyc, 4 - BYP);
    chk("b2b_first_pc", first_pc, 32'h0000_5000);
    chk("b2b_first_instr", first_instr, 32'h5000_AFFF);

    // Intermittent stall pattern
    stall_pat = 16'b0110_0011_1010_0100;
    for (int i = 0; i < 16; i++) run(1, stall_pat[i]);
    run(8, 1'b0);

    // Reset mid-stream, then a stray response with nothing outstanding
    lat = 3;
    run(8, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    gnt_mode = 2;
    stray = 1'b1;
    step(1'b0, 1'b0, 32'h0, 1'b0);
    stray = 1'b0;
    #2;
    chk("post_rst_valid", valid_o, 1'b0);
    chk("post_rst_addr", imem_addr_o, 32'h0000_0100);
    chk("post_rst_req", imem_req_o, 1'b1);
    gnt_mode = 0;
    lat = 1;
    run(8, 1'b0);
    settle();
    chk("post_rst_first_latency", first_cyc, 3 - BYP);
    chk("post_rst_first_pc", first_pc, 32'h0000_0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
